// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: nibble-serial add sequencer driving one external 4-bit
// ripple-carry adder. The two 4*NIBBLES-bit operands are walked least
// significant nibble first, one nibble per clock, with the carry held in a
// register between slices.
//
// Optional feature macro: RCA_SEQ_SUB_EN. When it is defined, a `sub` input
// is added. With sub=1 the sequencer computes op_a - op_b by loading ~op_b
// and a carry-in of 1, and cout=1 then means no borrow.
//
// Handshake: the requester raises `start` with op_a/op_b/cin (and sub) valid.
// The request is taken only on an edge where the block is idle; a start seen
// while busy or done is dropped, not queued. `done` pulses for exactly one
// cycle, and sum/cout are valid in that cycle. They hold until the next
// accepted start.
module rca_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  output logic [1:0]           dbg_state
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic [IW-1:0] r_idx;

  logic [W-1:0]  w_b_load;
  logic          w_carry_load;
  logic [IW+1:0] w_sel;

`ifdef RCA_SEQ_SUB_EN
  // Subtraction is a + ~b + 1, so only the B load and the initial carry change.
  always_comb begin
    w_b_load     = sub ? ~op_b : op_b;
    w_carry_load = sub ? 1'b1  : cin;
  end
`else
  // Add-only build: operands are loaded as given.
  always_comb begin
    w_b_load     = op_b;
    w_carry_load = cin;
  end
`endif

  assign w_sel = {r_idx, 2'b00};

  // Control and datapath registers: load on start, one nibble per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= w_b_load;
            r_carry <= w_carry_load;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[w_sel +: 4] <= add_s;
          r_carry           <= add_cout;
          if (r_idx == LAST_IDX) begin
            r_cout  <= add_cout;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Adder-side outputs: current nibble pair and carry in RUN, zero elsewhere.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (r_state == S_RUN) begin
      add_a   = r_a[w_sel +: 4];
      add_b   = r_b[w_sel +: 4];
      add_cin = r_carry;
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Testbench for rca_seq_ctrl: a 4-bit ripple-carry adder is attached to the
// add_* ports, and every finished operation is scoreboarded against a plain
// arithmetic model of a + b + cin (or a - b when RCA_SEQ_SUB_EN is defined).
module tb_rca_seq_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT and adder ----------------
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         cin;
  logic         sub_en;
  logic         busy, done, cout, add_cin, add_cout;
  logic [W-1:0] sum;
  logic [3:0]   add_a, add_b, add_s;
  logic [1:0]   dbg_state;

  rca_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
`ifdef RCA_SEQ_SUB_EN
    .sub      (sub_en),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout),
    .dbg_state(dbg_state)
  );

  logic [4:0] w_c;
  assign w_c[0] = add_cin;
  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign add_s[g]  = add_a[g] ^ add_b[g] ^ w_c[g];
    assign w_c[g+1]  = (add_a[g] & add_b[g]) | (w_c[g] & (add_a[g] ^ add_b[g]));
  end
  assign add_cout = w_c[4];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [W:0] last_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    return r;
  endfunction

  // Monitor: every done pulse pops one expectation and compares result and timing.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        check("result", {cout, sum}, exp_q.pop_front());
        check("done_cycle", cyc, exp_cyc_q.pop_front());
        check("adder_idle_in_done", {add_a, add_b, add_cin}, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issues one request for one cycle; the caller ensures the DUT is idle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; sub_en = s; start = 1'b1;
    last_exp = model(a, b, c, s);
    exp_q.push_back(last_exp);
    exp_cyc_q.push_back(cyc + 1 + NIBBLES);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits until the DUT is back in idle (neither busy nor done).
  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy=%0b done=%0b expected idle", busy, done);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s);
    issue(a, b, c, s);
    wait_idle(4 * NIBBLES + 10);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub_en = 1'b0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_adder", {add_a, add_b, add_cin}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: 0x1234 + 0x4321, with per-cycle busy/done profile.
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0; sub_en = 1'b0; start = 1'b1;
    last_exp = model(op_a, op_b, cin, 1'b0);
    check("model_1234_4321", last_exp, 17'h05555);
    exp_q.push_back(last_exp);
    exp_cyc_q.push_back(cyc + 1 + NIBBLES);
    for (int i = 1; i <= NIBBLES + 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("busy_profile_%0d", i), busy, (i <= NIBBLES) ? 1 : 0);
      check($sformatf("done_profile_%0d", i), done, (i == NIBBLES + 1) ? 1 : 0);
    end
    check("hold_sum_after_done", sum, 16'h5555);

    // Full carry ripple cases.
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("ripple_ffff_1", {cout, sum}, 17'h10000);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    check("ripple_ffff_cin", {cout, sum}, 17'h10000);

    // start held high with changing operands while busy: only the first is taken.
    @(negedge clk);
    op_a = 16'h0102; op_b = 16'h0304; cin = 1'b1; sub_en = 1'b0; start = 1'b1;
    last_exp = model(op_a, op_b, cin, 1'b0);
    exp_q.push_back(last_exp);
    exp_cyc_q.push_back(cyc + 1 + NIBBLES);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
    end
    start = 1'b0;
    wait_idle(20);
    repeat (NIBBLES + 3) @(negedge clk);
    check("storm_queue_empty", exp_q.size(), 0);
    check("storm_hold_result", {cout, sum}, last_exp);

    // Reset after the second RUN edge abandons the add with no done pulse.
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    check("midrun_rst_sum", sum, 0);
    check("midrun_rst_cout", cout, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    rst_n = 1'b1;
    repeat (NIBBLES + 4) @(negedge clk);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    check("after_rst_1_1", {cout, sum}, 17'h00002);

`ifdef RCA_SEQ_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    check("sub_5_7", {cout, sum}, 17'h0FFFE);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1);
    check("sub_7_5", {cout, sum}, 17'h10002);
`endif

    // Random operands with random idle gaps.
    for (int n = 0; n < 1000; n++) begin
      logic s;
      s = 1'b0;
`ifdef RCA_SEQ_SUB_EN
      s = 1'($urandom);
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom), s);
    end

    repeat (NIBBLES + 4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish by time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
